mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL provide ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL provide: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL provide: mem_valid_i  in  1  instruction present from EX/MEM register.
REQ-004 SHALL provide: mem_reg_we_i  in  1; mem_ren_i  in  1 (load); mem_wen_i  in  1 (store); mem_unsigned_i  in  1 (zero-extend load).
REQ-005 SHALL provide: mem_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-006 SHALL provide: mem_addr_i  in  32  ALU result, used as address or pass-through writeback data; mem_wdata_i  in  32  store data.
REQ-007 SHALL provide: dm_req_o  out  1; dm_we_o  out  1; dm_addr_o  out  32  word-aligned; dm_wstrb_o  out  4; dm_wdata_o  out  32; dm_ack_i  in  1; dm_rdata_i  in  32.
REQ-008 SHALL provide: mem_reg_we_o  out  1; mem_wD_o  out  32 (to MEM/WB register); mem_stall_o  out  1; mem_misalign_o  out  1; mem_bus_err_o  out  1.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-010 Non-memory op (valid, ren=wen=0) in IDLE SHALL pass through combinationally: mem_reg_we_o=mem_reg_we_i, mem_wD_o=mem_addr_i, stall 0.
REQ-011 Invalid slot (mem_valid_i=0) SHALL give mem_reg_we_o=0, stall 0, no request.
REQ-012 Misaligned op (half with addr[0]=1; word with addr[1:0]!=0) in IDLE SHALL assert mem_misalign_o that cycle, mem_reg_we_o=0, stall 0, no bus request, stay IDLE.
REQ-013 Aligned memory op in IDLE SHALL latch op fields, assert mem_stall_o, and transition to BUSY.
REQ-014 In BUSY, dm_req_o SHALL be 1 (registered) with stable dm_we_o, dm_addr_o={addr[31:2],2'b00}, dm_wstrb_o, dm_wdata_o until the ack cycle; mem_stall_o=1.
REQ-015 Store strobes SHALL be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; dm_wdata_o SHALL replicate the byte/half across all lanes.
REQ-016 On dm_ack_i in BUSY, a load SHALL capture the lane selected by addr[1:0], sign- or zero-extended per mem_unsigned_i, and go to DONE; dm_req_o SHALL drop the next cycle.
REQ-017 In DONE (one cycle), mem_stall_o=0; load: mem_reg_we_o=latched reg_we, mem_wD_o=captured data; store: mem_reg_we_o=0; then go to IDLE.
REQ-018 An 8-bit wait counter SHALL clear on BUSY entry and increment each BUSY cycle without ack; at 255 the access SHALL abort: mem_bus_err_o pulses in DONE, mem_reg_we_o=0 in DONE.
REQ-019 Ack and counter reaching 255 in the same cycle SHALL be treated as a normal ack (no error).
REQ-020 dm_ack_i outside BUSY SHALL be ignored.
REQ-021 Minimum residency: accept cycle + one BUSY cycle + DONE = 3 cycles, stall high for 2.
REQ-022 Upstream SHALL hold inputs stable while mem_stall_o=1; the block SHALL not re-sample op fields in BUSY/DONE.

Reset
REQ-023 While rst=1: state IDLE, dm_req_o=0, dm_we_o=0, dm_wstrb_o=0, counter 0, latched data 0, mem_reg_we_o=0, mem_stall_o=0, mem_misalign_o=0, mem_bus_err_o=0.
REQ-024 Reset asserted in BUSY SHALL drop dm_req_o at the next edge and discard the access; no writeback follows.

Verification
REQ-025 Load word addr 0x100, ack after 2 BUSY cycles, rdata 0xDEADBEEF -> stall 3 cycles, DONE: reg_we=1, wD=0xDEADBEEF.
REQ-026 Load byte signed addr 0x103, rdata 0x80112233 -> wD=0xFFFFFF80; unsigned -> 0x00000080.
REQ-027 Store half addr 0x202, wdata 0x0000ABCD -> dm_addr 0x200, wstrb 1100, wdata 0xABCDABCD, DONE reg_we=0.
REQ-028 Load word addr 0x101 -> misalign=1 one cycle, dm_req never asserted, stall 0, reg_we=0.
REQ-029 No ack for 255 BUSY cycles -> bus_err=1 in DONE, reg_we=0; repeat with ack on cycle 255 -> no error.
REQ-030 ALU op, addr 0x1234, reg_we=1 -> same cycle wD=0x1234, reg_we=1, stall 0; rst in BUSY -> dm_req 0 next cycle.

Source files
------------

// File: rtl/dm_if.sv
// dm_if: data-memory request/ack bus between the MEM stage (master) and memory (slave).
interface dm_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  modport master (output req, we, addr, wstrb, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wstrb, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage issuing aligned loads/stores on dm_if, with timeout abort.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        mem_reg_we_i,
  input  logic        mem_ren_i,
  input  logic        mem_wen_i,
  input  logic        mem_unsigned_i,
  input  logic [1:0]  mem_size_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  dm_if.master        dm,
  output logic        mem_reg_we_o,
  output logic [31:0] mem_wD_o,
  output logic        mem_stall_o,
  output logic        mem_misalign_o,
  output logic        mem_bus_err_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] ld_data;
  logic        reg_we_q, wen_q, uns_q, err_q;
  logic [1:0]  size_q, off_q;
  logic        mem_op, mis, idle, busy, done, go;
  logic [3:0]  strb;
  logic [31:0] wdat, lane, ext;
  always_comb begin
    mem_op = mem_valid_i & (mem_ren_i | mem_wen_i);
    mis = mem_size_i == 2'b01 ? mem_addr_i[0] : mem_size_i[1] ? |mem_addr_i[1:0] : 1'b0;
    idle = state == IDLE && !rst;
    busy = state == BUSY && !rst;
    done = state == DONE && !rst;
    go = idle & mem_op & ~mis;
    strb = mem_size_i == 2'b00 ? 4'b0001 << mem_addr_i[1:0] :
           mem_size_i == 2'b01 ? 4'b0011 << mem_addr_i[1:0] : 4'b1111;
    wdat = mem_size_i == 2'b00 ? {4{mem_wdata_i[7:0]}} :
           mem_size_i == 2'b01 ? {2{mem_wdata_i[15:0]}} : mem_wdata_i;
    lane = dm.rdata >> {off_q, 3'b000};
    ext = size_q == 2'b00 ? {{24{~uns_q & lane[7]}}, lane[7:0]} :
          size_q == 2'b01 ? {{16{~uns_q & lane[15]}}, lane[15:0]} : lane;
    mem_misalign_o = idle & mem_op & mis;
    mem_stall_o = go | busy;
    mem_reg_we_o = idle ? mem_valid_i & ~mem_op & mem_reg_we_i : done & reg_we_q & ~wen_q & ~err_q;
    mem_wD_o = idle ? mem_addr_i : ld_data;
    mem_bus_err_o = done & err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dm.req <= 1'b0;
      dm.we <= 1'b0;
      dm.addr <= '0;
      dm.wstrb <= '0;
      dm.wdata <= '0;
      cnt <= '0;
      ld_data <= '0;
      reg_we_q <= 1'b0;
      wen_q <= 1'b0;
      uns_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= '0;
      off_q <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          state <= BUSY;
          dm.req <= 1'b1;
          dm.we <= mem_wen_i;
          dm.addr <= {mem_addr_i[31:2], 2'b00};
          dm.wstrb <= mem_wen_i ? strb : 4'b0000;
          dm.wdata <= wdat;
          cnt <= '0;
          err_q <= 1'b0;
          reg_we_q <= mem_reg_we_i;
          wen_q <= mem_wen_i;
          uns_q <= mem_unsigned_i;
          size_q <= mem_size_i;
          off_q <= mem_addr_i[1:0];
        end
        BUSY: if (dm.ack) begin
          state <= DONE;
          dm.req <= 1'b0;
          dm.we <= 1'b0;
          dm.wstrb <= '0;
          if (!wen_q) ld_data <= ext;
        end else begin
          cnt <= cnt + 8'd1;
          // this no-ack cycle brings the counter to 255: give up
          if (cnt == 8'd254) begin
            state <= DONE;
            dm.req <= 1'b0;
            dm.we <= 1'b0;
            dm.wstrb <= '0;
            err_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a behavioural model.
module tb_mem_stage;
  logic clk = 0, rst = 1;
  logic valid = 0, rwe = 0, ren = 0, wen = 0, uns = 0;
  logic [1:0] sz = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic reg_we_o, stall_o, mis_o, err_o;
  logic [31:0] wd_o;
  int n_cmp = 0, n_bad = 0;
  dm_if dm();
  mem_stage dut (
    .clk(clk), .rst(rst), .mem_valid_i(valid), .mem_reg_we_i(rwe), .mem_ren_i(ren),
    .mem_wen_i(wen), .mem_unsigned_i(uns), .mem_size_i(sz), .mem_addr_i(addr),
    .mem_wdata_i(wdata), .dm(dm), .mem_reg_we_o(reg_we_o), .mem_wD_o(wd_o),
    .mem_stall_o(stall_o), .mem_misalign_o(mis_o), .mem_bus_err_o(err_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_load(logic [1:0] s, logic u, logic [31:0] a, logic [31:0] rd);
    int idx;
    longint v;
    idx = int'(a[1:0]);
    v = longint'(rd);
    if (s == 2'd0) begin
      v = (rd >> (8 * idx)) & 255;
      if (!u && v >= 128) v -= 256;
    end else if (s == 2'd1) begin
      v = (rd >> (8 * idx)) & 65535;
      if (!u && v >= 32768) v -= 65536;
    end
    return v[31:0];
  endfunction
  function automatic logic [31:0] exp_strb(logic [1:0] s, logic [31:0] a);
    int idx;
    idx = int'(a[1:0]);
    return s == 2'd0 ? 32'(1 << idx) : s == 2'd1 ? 32'(3 << idx) : 32'hF;
  endfunction
  function automatic logic [31:0] exp_wdata(logic [1:0] s, logic [31:0] d);
    return s == 2'd0 ? d[7:0] * 32'h01010101 : s == 2'd1 ? d[15:0] * 32'h00010001 : d;
  endfunction
  task automatic run_op(input logic v, input logic we_in, input logic r, input logic w, input logic u,
                        input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                        input int lat, input logic [31:0] rd);
    logic mop, mal, err;
    int nb;
    @(posedge clk); #1;
    valid = v; rwe = we_in; ren = r; wen = w; uns = u; sz = s; addr = a; wdata = d;
    dm.ack = 1'($urandom_range(0, 1));
    dm.rdata = $urandom;
    mop = v && (r || w);
    mal = (s == 2'd1 && a[0]) || (s[1] && a[1:0] != 2'b00);
    @(negedge clk);
    if (!mop) begin
      check("pass_we", reg_we_o, v && we_in);
      check("pass_stall", stall_o, 0);
      check("pass_mis", mis_o, 0);
      check("pass_err", err_o, 0);
      check("pass_req", dm.req, 0);
      if (v) check("pass_wd", wd_o, a);
      return;
    end
    if (mal) begin
      check("mis_flag", mis_o, 1);
      check("mis_stall", stall_o, 0);
      check("mis_we", reg_we_o, 0);
      check("mis_req", dm.req, 0);
      @(posedge clk); #1;
      valid = 0;
      @(negedge clk);
      check("mis_req_after", dm.req, 0);
      check("mis_flag_after", mis_o, 0);
      return;
    end
    check("acc_stall", stall_o, 1);
    check("acc_mis", mis_o, 0);
    check("acc_we", reg_we_o, 0);
    check("acc_req", dm.req, 0);
    err = lat > 255;
    nb = 0;
    while (nb < 255 && nb != lat) begin
      @(posedge clk); #1;
      nb++;
      dm.ack = (nb == lat);
      dm.rdata = (nb == lat) ? rd : $urandom;
      @(negedge clk);
      check("busy_req", dm.req, 1);
      check("busy_stall", stall_o, 1);
      check("busy_we", dm.we, w);
      check("busy_addr", dm.addr, a & ~32'h3);
      if (w) begin
        check("busy_strb", dm.wstrb, exp_strb(s, a));
        check("busy_wdata", dm.wdata, exp_wdata(s, d));
      end
    end
    @(posedge clk); #1;
    dm.ack = 1'($urandom_range(0, 1));
    dm.rdata = $urandom;
    valid = 1'($urandom_range(0, 1)); rwe = 1'($urandom_range(0, 1)); ren = 1'($urandom_range(0, 1));
    wen = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); addr = $urandom; wdata = $urandom;
    @(negedge clk);
    check("done_req", dm.req, 0);
    check("done_stall", stall_o, 0);
    check("done_mis", mis_o, 0);
    check("done_err", err_o, err);
    check("done_we", reg_we_o, !w && !err && we_in);
    if (!w && !err) check("done_wd", wd_o, exp_load(s, u, a, rd));
  endtask
  initial begin
    #200000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    dm.ack = 0;
    dm.rdata = 0;
    valid = 1; rwe = 1; ren = 1; sz = 2'd2; addr = 32'h100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", dm.req, 0);
    check("rst_we", dm.we, 0);
    check("rst_strb", dm.wstrb, 0);
    check("rst_stall", stall_o, 0);
    check("rst_mis", mis_o, 0);
    check("rst_err", err_o, 0);
    check("rst_regwe", reg_we_o, 0);
    @(posedge clk); #1;
    rst = 0; valid = 0;
    run_op(1, 1, 1, 0, 0, 2'd2, 32'h100, 0, 2, 32'hDEADBEEF);
    run_op(1, 1, 1, 0, 0, 2'd0, 32'h103, 0, 1, 32'h80112233);
    check("ldb_signed", wd_o, 32'hFFFFFF80);
    run_op(1, 1, 1, 0, 1, 2'd0, 32'h103, 0, 1, 32'h80112233);
    check("ldb_unsigned", wd_o, 32'h00000080);
    run_op(1, 0, 0, 1, 0, 2'd1, 32'h202, 32'h0000ABCD, 1, 0);
    run_op(1, 1, 1, 0, 0, 2'd2, 32'h101, 0, 1, 0);
    run_op(1, 1, 1, 0, 0, 2'd2, 32'h300, 0, 300, 32'h12345678);
    run_op(1, 1, 1, 0, 0, 2'd2, 32'h304, 0, 255, 32'h12345678);
    run_op(1, 1, 1, 0, 0, 2'd2, 32'h308, 0, 254, 32'hCAFEF00D);
    run_op(1, 1, 0, 0, 0, 2'd2, 32'h1234, 0, 1, 0);
    run_op(0, 1, 1, 0, 0, 2'd2, 32'h100, 0, 1, 0);
    // reset while the bus request is outstanding
    @(posedge clk); #1;
    valid = 1; rwe = 1; ren = 1; wen = 0; sz = 2'd2; addr = 32'h400; dm.ack = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rb_req_busy", dm.req, 1);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    check("rb_stall_rst", stall_o, 0);
    check("rb_we_rst", reg_we_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rb_req_drop", dm.req, 0);
    @(posedge clk); #1;
    rst = 0; valid = 0; dm.ack = 1;
    @(negedge clk);
    check("rb_req_after", dm.req, 0);
    check("rb_we_after", reg_we_o, 0);
    check("rb_stall_after", stall_o, 0);
    for (int i = 0; i < 200; i++) begin
      logic [1:0] s;
      logic [31:0] a;
      int kind, r, lat;
      kind = $urandom_range(0, 2);
      s = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = s == 2'd0 ? a : s == 2'd1 ? a & ~32'h1 : a & ~32'h3;
      r = $urandom_range(0, 19);
      lat = r == 0 ? 255 + $urandom_range(0, 2) : r == 1 ? 254 : $urandom_range(1, 4);
      run_op(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), kind == 1, kind == 2,
             1'($urandom_range(0, 1)), s, a, $urandom, lat, $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
